// File: rtl/parity_arb_pkg.sv
// Shared types and helpers for the parity engine arbiter.
// State encoding, id width helper and default watchdog limit.
package parity_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FWD      = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_t;

  localparam int DEF_RSP_TIMEOUT = 256;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parity_rr_pick.sv
// Combinational round-robin selector.
// Ports: req (requests), ptr (last winner) -> found, idx (winner).
module parity_rr_pick
  import parity_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             found,
  output logic [IW-1:0]    idx
);

  int j;

  // Search starts one past the previous winner.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/parity_axis_arbiter.sv
// Shares one parity engine between N_REQ AXI-Stream requesters.
// Ports: req_s_* in, eng_m_*/eng_s_* engine, rsp_m_* out, status.
module parity_axis_arbiter
  import parity_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int RSP_TIMEOUT = DEF_RSP_TIMEOUT
) (
  input  logic                   a_clk,
  input  logic                   axis_areset,
  input  logic [N_REQ-1:0]       req_s_tvalid,
  input  logic [8*N_REQ-1:0]     req_s_tdata,
  input  logic [N_REQ-1:0]       req_s_tlast,
  output logic [N_REQ-1:0]       req_s_tready,
  output logic                   eng_m_tvalid,
  output logic [7:0]             eng_m_tdata,
  output logic                   eng_m_tlast,
  input  logic                   eng_m_tready,
  input  logic                   eng_s_tvalid,
  input  logic [7:0]             eng_s_tdata,
  input  logic                   eng_s_tlast,
  output logic                   eng_s_tready,
  output logic [N_REQ-1:0]       rsp_m_tvalid,
  output logic [7:0]             rsp_m_tdata,
  output logic                   rsp_m_tlast,
  input  logic [N_REQ-1:0]       rsp_m_tready,
  output logic                   busy,
  output logic [id_w(N_REQ)-1:0] grant_id,
  output logic                   timeout_err,
  output logic [7:0]             err_count
);

  localparam int IW = id_w(N_REQ);

  arb_state_t state, nxt;
  logic [IW-1:0] g, rr_ptr, pick_idx;
  logic pick_found, rsp_done;
  logic [31:0] timer;
  logic in_fwd, in_wait, rsp_en;
  logic req_last, rsp_hs, rsp_last;
  logic wd_fire, to_idle;

  parity_rr_pick #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_pick (
    .req  (req_s_tvalid),
    .ptr  (rr_ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  assign in_fwd  = (state == FWD);
  assign in_wait = (state == WAIT_RSP);
  // Once the response tlast has passed, further beats are held off.
  assign rsp_en  = in_wait | (in_fwd & ~rsp_done);

  assign req_last = in_fwd & req_s_tvalid[g]
                  & eng_m_tready & req_s_tlast[g];
  assign rsp_hs   = rsp_en & eng_s_tvalid & rsp_m_tready[g];
  assign rsp_last = rsp_hs & eng_s_tlast;
  assign wd_fire  = (RSP_TIMEOUT != 0) && in_wait && !rsp_hs
                 && (timer == 32'(RSP_TIMEOUT - 1));

  always_comb begin
    eng_m_tvalid = in_fwd & req_s_tvalid[g];
    eng_m_tdata  = req_s_tdata[8*int'(g) +: 8];
    eng_m_tlast  = in_fwd & req_s_tlast[g];
    req_s_tready = '0;
    if (in_fwd) req_s_tready[g] = eng_m_tready;
    rsp_m_tvalid = '0;
    if (rsp_en) rsp_m_tvalid[g] = eng_s_tvalid;
    eng_s_tready = rsp_en & rsp_m_tready[g];
    rsp_m_tdata  = eng_s_tdata;
    rsp_m_tlast  = eng_s_tlast;
    busy         = (state != IDLE);
    grant_id     = busy ? g : '0;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (pick_found) nxt = FWD;
      FWD:      if (req_last)
                  nxt = (rsp_done | rsp_last) ? IDLE : WAIT_RSP;
      WAIT_RSP: if (rsp_last || wd_fire) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    to_idle = (state != IDLE) && (nxt == IDLE);
  end

  always_ff @(posedge a_clk or posedge axis_areset) begin
    if (axis_areset) state <= IDLE;
    else             state <= nxt;
  end

  always_ff @(posedge a_clk or posedge axis_areset) begin
    if (axis_areset) begin
      rr_ptr      <= IW'(N_REQ - 1);
      g           <= '0;
      rsp_done    <= 1'b0;
      timer       <= '0;
      err_count   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_fire;
      if (wd_fire && err_count != 8'hff)
        err_count <= err_count + 8'd1;
      if (state == IDLE && pick_found)
        g <= pick_idx;
      if (to_idle) begin
        rr_ptr   <= g;
        rsp_done <= 1'b0;
        timer    <= '0;
      end else begin
        if (in_fwd && rsp_last) rsp_done <= 1'b1;
        if (in_wait) timer <= rsp_hs ? '0 : timer + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_parity_axis_arbiter.sv
// Scoreboard bench for parity_axis_arbiter.
// Directed packets; a negedge monitor checks all handshakes.
module tb_parity_axis_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic a_clk = 1'b0;
  logic axis_areset;
  always #5 a_clk = ~a_clk;

  logic       rv[N];
  logic [7:0] rd[N];
  logic       rl[N];

  logic [N-1:0]   req_s_tvalid, req_s_tlast, req_s_tready;
  logic [8*N-1:0] req_s_tdata;
  logic           eng_m_tvalid, eng_m_tlast, eng_m_tready;
  logic [7:0]     eng_m_tdata;
  logic           eng_s_tvalid, eng_s_tlast, eng_s_tready;
  logic [7:0]     eng_s_tdata;
  logic [N-1:0]   rsp_m_tvalid, rsp_m_tready;
  logic [7:0]     rsp_m_tdata;
  logic           rsp_m_tlast;
  logic           busy, timeout_err;
  logic [0:0]     grant_id;
  logic [7:0]     err_count;

  assign req_s_tvalid = {rv[1], rv[0]};
  assign req_s_tlast  = {rl[1], rl[0]};
  assign req_s_tdata  = {rd[1], rd[0]};

  parity_axis_arbiter #(
    .N_REQ      (N),
    .RSP_TIMEOUT(TO)
  ) dut (
    .a_clk       (a_clk),
    .axis_areset (axis_areset),
    .req_s_tvalid(req_s_tvalid),
    .req_s_tdata (req_s_tdata),
    .req_s_tlast (req_s_tlast),
    .req_s_tready(req_s_tready),
    .eng_m_tvalid(eng_m_tvalid),
    .eng_m_tdata (eng_m_tdata),
    .eng_m_tlast (eng_m_tlast),
    .eng_m_tready(eng_m_tready),
    .eng_s_tvalid(eng_s_tvalid),
    .eng_s_tdata (eng_s_tdata),
    .eng_s_tlast (eng_s_tlast),
    .eng_s_tready(eng_s_tready),
    .rsp_m_tvalid(rsp_m_tvalid),
    .rsp_m_tdata (rsp_m_tdata),
    .rsp_m_tlast (rsp_m_tlast),
    .rsp_m_tready(rsp_m_tready),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err),
    .err_count   (err_count)
  );

  beat_t exp_req[N][$];
  beat_t exp_rsp[N][$];
  int    exp_grant[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    req_last_cnt = 0;
  logic  tog;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail(string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got no event, required one within bound", nm);
  endfunction

  // Monitor: every handshake is popped against the scoreboard.
  always @(negedge a_clk) begin
    int    g;
    beat_t b;
    if (!axis_areset) begin
      if (eng_m_tvalid && eng_m_tready) begin
        g = int'(grant_id);
        if (exp_req[g].size() == 0) begin
          chk("req_unexpected", {24'h0, eng_m_tdata}, 32'hffff_ffff);
        end else begin
          b = exp_req[g].pop_front();
          chk("req_data", {24'h0, eng_m_tdata}, {24'h0, b.d});
          chk("req_last", {31'h0, eng_m_tlast}, {31'h0, b.l});
        end
        if (eng_m_tlast) begin
          req_last_cnt++;
          if (exp_grant.size() > 0)
            chk("grant", {31'h0, grant_id}, exp_grant.pop_front());
        end
      end
      for (int i = 0; i < N; i++) begin
        if (rsp_m_tvalid[i] && rsp_m_tready[i]) begin
          if (exp_rsp[i].size() == 0) begin
            chk($sformatf("rsp%0d_unexpected", i),
                {24'h0, rsp_m_tdata}, 32'hffff_ffff);
          end else begin
            b = exp_rsp[i].pop_front();
            chk("rsp_data", {24'h0, rsp_m_tdata}, {24'h0, b.d});
            chk("rsp_last", {31'h0, rsp_m_tlast}, {31'h0, b.l});
          end
        end
      end
      if (!busy) begin
        chk("idle_mask",
            {26'h0, req_s_tready, rsp_m_tvalid,
             eng_m_tvalid, eng_s_tready}, 32'h0);
      end else begin
        chk("loser_ready",
            {30'h0, req_s_tready & ~(N'(1) << grant_id)}, 32'h0);
        chk("rsp_onehot", {31'h0, ($countones(rsp_m_tvalid) > 1)}, 32'h0);
      end
    end
  end

  task automatic send_pkt(input int r, input int n,
                          input logic [31:0] bytes);
    beat_t b;
    bit    ok;
    for (int k = 0; k < n; k++) begin
      b.d = bytes[8*k +: 8];
      b.l = (k == n - 1);
      rv[r] = 1'b1;
      rd[r] = b.d;
      rl[r] = b.l;
      exp_req[r].push_back(b);
      ok = 1'b0;
      for (int c = 0; c < 300 && !ok; c++) begin
        @(negedge a_clk);
        if (req_s_tready[r]) ok = 1'b1;
      end
      if (!ok) fail($sformatf("req%0d_stall", r));
      @(posedge a_clk);
      #1;
    end
    rv[r] = 1'b0;
    rl[r] = 1'b0;
  endtask

  task automatic send_rsp(input int r, input int n,
                          input logic [31:0] bytes);
    beat_t b;
    bit    ok;
    for (int k = 0; k < n; k++) begin
      b.d = bytes[8*k +: 8];
      b.l = (k == n - 1);
      eng_s_tvalid = 1'b1;
      eng_s_tdata  = b.d;
      eng_s_tlast  = b.l;
      exp_rsp[r].push_back(b);
      ok = 1'b0;
      for (int c = 0; c < 300 && !ok; c++) begin
        @(negedge a_clk);
        if (eng_s_tready) ok = 1'b1;
      end
      if (!ok) fail($sformatf("rsp%0d_stall", r));
      @(posedge a_clk);
      #1;
    end
    eng_s_tvalid = 1'b0;
    eng_s_tlast  = 1'b0;
  endtask

  // Both requesters stream npkt one-beat packets; engine answers each.
  task automatic contention(input int first, input int npkt);
    int base;
    base = req_last_cnt;
    for (int k = 0; k < 2*npkt; k++) exp_grant.push_back((first + k) % 2);
    fork
      for (int p = 0; p < npkt; p++) send_pkt(0, 1, 32'h10 + p);
      for (int p = 0; p < npkt; p++) send_pkt(1, 1, 32'h20 + p);
      for (int k = 0; k < 2*npkt; k++) begin
        for (int c = 0; c < 300 && req_last_cnt <= base + k; c++)
          @(posedge a_clk);
        if (req_last_cnt <= base + k) fail("eng_wait_req");
        #1;
        send_rsp((first + k) % 2, 1, 32'h70 + k);
      end
    join
  endtask

  initial begin
    int n;
    bit ok;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0;
      rd[i] = 8'h0;
      rl[i] = 1'b0;
    end
    eng_m_tready = 1'b1;
    eng_s_tvalid = 1'b0;
    eng_s_tdata  = 8'h0;
    eng_s_tlast  = 1'b0;
    rsp_m_tready = '1;
    tog          = 1'b0;
    axis_areset  = 1'b1;
    repeat (3) @(posedge a_clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_grant", {31'h0, grant_id}, 32'h0);
    chk("rst_errcnt", {24'h0, err_count}, 32'h0);
    chk("rst_tmo", {31'h0, timeout_err}, 32'h0);
    chk("rst_valid", {31'h0, eng_m_tvalid}, 32'h0);
    axis_areset = 1'b0;

    // Single requester, three-beat request and response.
    send_pkt(0, 3, 32'h0083_0201);
    chk("t1_busy_wait", {31'h0, busy}, 32'h1);
    send_rsp(0, 3, 32'h00de_12ab);
    chk("t1_busy_fall", {31'h0, busy}, 32'h0);

    // Contention: last grant was 0, so 1 leads.
    contention(1, 2);

    // Backpressure on both sides, requester 1.
    tog = 1'b1;
    fork
      begin
        send_pkt(1, 4, 32'h4443_4241);
        tog = 1'b0;
      end
      while (tog) begin
        @(posedge a_clk);
        #1;
        eng_m_tready = ~eng_m_tready;
      end
    join
    eng_m_tready = 1'b1;
    rsp_m_tready[1] = 1'b0;
    fork
      send_rsp(1, 3, 32'h0063_6261);
      begin
        repeat (5) begin
          @(negedge a_clk);
          chk("t3_mirror0", {31'h0, eng_s_tready}, 32'h0);
          chk("t3_rsp_valid", {30'h0, rsp_m_tvalid}, 32'h2);
        end
        #1;
        rsp_m_tready[1] = 1'b1;
        @(negedge a_clk);
        chk("t3_mirror1", {31'h0, eng_s_tready}, 32'h1);
      end
    join

    // Early response before request tlast.
    eng_m_tready = 1'b0;
    fork
      send_pkt(0, 3, 32'h0023_2221);
      begin
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
          @(posedge a_clk);
          #1;
          ok = busy;
        end
        if (!ok) fail("t4_grant");
        send_rsp(0, 1, 32'hff);
        eng_s_tvalid = 1'b1;
        eng_s_tdata  = 8'hee;
        eng_s_tlast  = 1'b1;
        @(negedge a_clk);
        chk("t4_holdoff", {31'h0, eng_s_tready}, 32'h0);
        chk("t4_rsp_mask", {30'h0, rsp_m_tvalid}, 32'h0);
        @(posedge a_clk);
        #1;
        eng_s_tvalid = 1'b0;
        eng_s_tlast  = 1'b0;
        eng_m_tready = 1'b1;
      end
    join
    chk("t4_no_wait_rsp", {31'h0, busy}, 32'h0);

    // Watchdog: engine silent after requester 1's packet.
    send_pkt(1, 1, 32'h55);
    n = 41;
    for (int c = 1; c <= 40; c++) begin
      @(posedge a_clk);
      #1;
      if (timeout_err) begin
        n = c;
        break;
      end
    end
    chk("t5_tmo_cycle", n, 32'd16);
    chk("t5_errcnt", {24'h0, err_count}, 32'h1);
    chk("t5_idle", {31'h0, busy}, 32'h0);
    @(posedge a_clk);
    #1;
    chk("t5_pulse", {31'h0, timeout_err}, 32'h0);
    contention(0, 1);

    // Reset mid-packet; make rr_ptr 0 first so reset is visible.
    send_pkt(0, 1, 32'h66);
    send_rsp(0, 1, 32'h67);
    rv[1] = 1'b1;
    rd[1] = 8'h71;
    rl[1] = 1'b0;
    exp_req[1].push_back(beat_t'{d: 8'h71, l: 1'b0});
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge a_clk);
      if (req_s_tready[1]) ok = 1'b1;
    end
    if (!ok) fail("t6_beat1");
    @(posedge a_clk);
    #1;
    eng_m_tready = 1'b0;
    rd[1] = 8'h72;
    @(negedge a_clk);
    chk("t6_beat2_valid", {31'h0, eng_m_tvalid}, 32'h1);
    #1;
    eng_m_tready = 1'b1;
    #1;
    chk("t6_pre_ready", {30'h0, req_s_tready}, 32'h2);
    axis_areset = 1'b1;
    #1;
    chk("t6_rst_valid", {31'h0, eng_m_tvalid}, 32'h0);
    chk("t6_rst_ready", {30'h0, req_s_tready}, 32'h0);
    chk("t6_rst_busy", {31'h0, busy}, 32'h0);
    chk("t6_rst_errcnt", {24'h0, err_count}, 32'h0);
    rv[1] = 1'b0;
    repeat (2) @(posedge a_clk);
    #1;
    axis_areset = 1'b0;
    contention(0, 1);

    repeat (5) @(posedge a_clk);
    for (int i = 0; i < N; i++) begin
      chk("req_q_empty", exp_req[i].size(), 32'h0);
      chk("rsp_q_empty", exp_rsp[i].size(), 32'h0);
    end
    chk("grant_q_empty", exp_grant.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required one");
    $fatal(1);
  end

endmodule

// File: doc/parity_axis_arbiter.md
Name: parity_axis_arbiter

Overview:
- Shares one parity-tester engine between N_REQ AXI-Stream requesters.
- Grants the engine to one requester for one full request packet, forwarding beats until tlast.
- Routes the engine's response packet back to that same requester, then rotates the grant round-robin.
- Watchdog timeout on the response phase; sits between requester DMA/streams and the engine.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- RSP_TIMEOUT, 256, idle cycles allowed between response handshakes before abort; 0 disables the watchdog.

Ports:
- a_clk  in  1  clock.
- axis_areset  in  1  asynchronous reset, active-high.
- req_s_tvalid  in  N_REQ  per-requester request valid.
- req_s_tdata  in  8*N_REQ  per-requester request byte; requester i uses bits [8i+7:8i].
- req_s_tlast  in  N_REQ  per-requester request last.
- req_s_tready  out  N_REQ  per-requester request ready.
- eng_m_tvalid  out  1  request valid to engine.
- eng_m_tdata  out  8  request byte to engine.
- eng_m_tlast  out  1  request last to engine.
- eng_m_tready  in  1  engine ready.
- eng_s_tvalid  in  1  response valid from engine.
- eng_s_tdata  in  8  response byte from engine.
- eng_s_tlast  in  1  response last from engine.
- eng_s_tready  out  1  ready to engine.
- rsp_m_tvalid  out  N_REQ  per-requester response valid.
- rsp_m_tdata  out  8  response byte, broadcast; qualified by rsp_m_tvalid.
- rsp_m_tlast  out  1  response last, broadcast.
- rsp_m_tready  in  N_REQ  per-requester response ready.
- busy  out  1  high in any state except IDLE.
- grant_id  out  clog2(N_REQ)  current owner; 0 when idle.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- err_count  out  8  saturating count of timeouts.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE; rr_ptr = N_REQ-1, so requester 0 wins first; grant_id = 0; rsp_done = 0; timer = 0; err_count = 0; timeout_err = 0.
  - All valid/ready outputs are combinationally masked by state, so they drop immediately on reset assertion.
- States: IDLE, FWD, WAIT_RSP.
- IDLE:
  - Pick the first i with req_s_tvalid[i] = 1, searching from rr_ptr+1 modulo N_REQ.
  - Register grant_id = i; move to FWD next cycle.
  - All readies and valids are 0 in IDLE.
  - Arbitration latency: 1 cycle from tvalid to the first forwardable beat.
- FWD:
  - Combinational passthrough: eng_m_tvalid = req_s_tvalid[g]; eng_m_tdata/tlast from requester g; req_s_tready[g] = eng_m_tready.
  - All other req_s_tready bits are 0.
  - On a request handshake with tlast: go to WAIT_RSP, or to IDLE if rsp_done = 1.
- Response routing (FWD and WAIT_RSP):
  - rsp_m_tvalid[g] = eng_s_tvalid; eng_s_tready = rsp_m_tready[g]; other rsp_m_tvalid bits are 0.
  - A response handshake with tlast during FWD sets rsp_done; any later response beats are held off (eng_s_tready = 0).
  - A response handshake with tlast during WAIT_RSP moves to IDLE.
- Every move to IDLE sets rr_ptr = g and clears rsp_done and timer.
- Simultaneous: request-tlast and response-tlast handshakes in the same FWD cycle go directly to IDLE.
- Watchdog:
  - Active in WAIT_RSP only.
  - timer increments each cycle without a response handshake and clears on any response handshake.
  - When timer reaches RSP_TIMEOUT-1 with no handshake: pulse timeout_err, increment err_count (saturating at 255), go to IDLE.
- Request beats are never dropped; the requester holds data until its tready is asserted (standard AXIS).
- Zero-length packets do not exist; the minimum packet is one beat with tlast.

Decomposition:
- Package parity_arb_pkg holds:
  - the state encoding (IDLE = 0, FWD = 1, WAIT_RSP = 2);
  - the ID-width function (clog2);
  - the default RSP_TIMEOUT.
- One sub-module, parity_rr_pick: a combinational round-robin selector with inputs req[N_REQ] and ptr, outputs found and idx.

Test Plan:
- Single requester: req0 sends 3 beats 0x01,0x02,0x83 with tlast on 0x83; engine responds 0xab,0x12,0xde with tlast on 0xde. Required: bytes forwarded unchanged; response appears only on rsp_m_tvalid[0]; busy falls the cycle after the response tlast.
- Contention: req0 and req1 valid continuously, 1-beat packets. Required: grants alternate 0,1,0,1; req_s_tready of the loser stays 0 throughout.
- Backpressure: eng_m_tready toggles 1,0,1,0 and rsp_m_tready[1] is held 0 for 5 cycles. Required: no beat lost or duplicated; eng_s_tready mirrors rsp_m_tready[1].
- Early response: engine returns 1-beat response 0xff with tlast before the request tlast. Required: rsp_done set; state goes to IDLE on request tlast, never enters WAIT_RSP.
- Timeout: RSP_TIMEOUT = 16, engine silent after request. Required: timeout_err pulses exactly 16 cycles after entering WAIT_RSP; err_count = 1; next requester granted.
- Reset mid-FWD: assert axis_areset during beat 2 of a packet. Required: all valids/readies drop the same cycle; after release, requester 0 wins first.
